// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, sizes and small-sigma helpers.
// Pure package: no logic, no latency.
// Used by the message schedule, the word-expansion datapath and the compression core.
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int SHA256_BLOCK_W = 512;
    localparam int SHA256_WORDS   = 16;
    localparam int SHA256_ROUNDS  = 64;

    // Rotate right by n (0 < n < 32).
    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t sigma0_small(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sigma1_small(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// Purpose: next schedule word from a 16-word window holding W[t..t+15].
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume new_w.
// Ports: w0/w1/w9/w14 = window taps win[0], win[1], win[9], win[14]; new_w = W[t+16].
module sha256_w_expand
    import sha256_pkg::*;
(
    input  word_t w0,
    input  word_t w1,
    input  word_t w9,
    input  word_t w14,
    output word_t new_w
);

    // With win[i] = W[t+i], this is the textbook
    // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t], wrapping mod 2^32.
    assign new_w = sigma1_small(w14) + w9 + sigma0_small(w1) + w0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// Purpose: accept one padded 512-bit block and stream W[0..NUM_ROUNDS-1], one word per handshake.
// Latency: block accepted at cycle N gives W[0] at N+1; last word at N+NUM_ROUNDS; next block at N+NUM_ROUNDS+1.
// Backpressure: valid/ready on both sides; while w_valid && !w_ready the outputs and window hold.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   blk_valid/blk_ready/blk_data      block input; word 0 in [511:480], word 15 in [31:0]
//   w_valid/w_ready/w_data            round word output W[t]
//   w_idx, w_last                     round index t; w_last marks t == NUM_ROUNDS-1 while valid
// NUM_ROUNDS legal range is 17..64; values below 64 are for reduced-round testing only.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS = SHA256_ROUNDS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      blk_valid,
    output logic                      blk_ready,
    input  logic [SHA256_BLOCK_W-1:0] blk_data,
    output logic                      w_valid,
    input  logic                      w_ready,
    output logic [31:0]               w_data,
    output logic [5:0]                w_idx,
    output logic                      w_last
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

    state_t state;
    word_t  win [SHA256_WORDS];
    logic   [5:0] idx;
    word_t  new_w;

    sha256_w_expand u_expand (
        .w0    (win[0]),
        .w1    (win[1]),
        .w9    (win[9]),
        .w14   (win[14]),
        .new_w (new_w)
    );

    // Gating with rst makes a same-cycle rst + blk_valid never look like an accept upstream.
    assign blk_ready = (state == IDLE) && !rst;

    // Outputs come straight from registers: the window head is W[t] by construction.
    assign w_valid = (state == RUN);
    assign w_data  = win[0];
    assign w_idx   = idx;
    assign w_last  = (state == RUN) && (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            for (int i = 0; i < SHA256_WORDS; i++) begin
                win[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (blk_valid) begin
                        for (int i = 0; i < SHA256_WORDS; i++) begin
                            win[i] <= blk_data[SHA256_BLOCK_W-1-32*i -: 32];
                        end
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (w_ready) begin
                        // Expansion runs even for t < 16 so the window always holds W[t..t+15].
                        for (int i = 0; i < SHA256_WORDS - 1; i++) begin
                            win[i] <= win[i+1];
                        end
                        win[SHA256_WORDS-1] <= new_w;
                        // idx stops at the last round rather than wrapping; a new load clears it.
                        if (idx == LAST_IDX) begin
                            state <= IDLE;
                        end else begin
                            idx <= idx + 6'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule: a reference schedule built with the
// textbook W[t] recurrence drives a scoreboard queue that a negedge monitor checks every cycle.
module tb_sha256_msg_schedule;

    localparam int NR = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_data;
    logic [5:0]   w_idx;
    logic         w_last;

    sha256_msg_schedule #(.NUM_ROUNDS(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_idx     (w_idx),
        .w_last    (w_last)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    // Full schedule, W[t] packed at bits [t*32 +: 32].
    function automatic logic [64*32-1:0] sched(input logic [511:0] blk);
        logic [31:0]         w [64];
        logic [64*32-1:0]    r;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
        r = '0;
        for (int t = 0; t < 64; t++) r[t*32 +: 32] = w[t];
        return r;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [31:0] d;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    exp_t exp_q [$];
    int   cyc         = 0;
    int   last_hs_cyc = -100;
    int   acc_cyc     = -1;
    logic model_idle;
    logic [64*32-1:0] mon_s;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("blk_ready_in_rst", {31'd0, blk_ready}, 32'd0);
            exp_q.delete();
        end else begin
            model_idle = (exp_q.size() == 0);
            chk("blk_ready", {31'd0, blk_ready}, {31'd0, model_idle});
            chk("w_valid", {31'd0, w_valid}, {31'd0, !model_idle});
            if (model_idle) begin
                chk("w_last_idle", {31'd0, w_last}, 32'd0);
                if (blk_valid) begin
                    mon_s = sched(blk_data);
                    for (int t = 0; t < NR; t++) begin
                        exp_q.push_back('{d: mon_s[t*32 +: 32], idx: 6'(t), last: (t == NR - 1)});
                    end
                    acc_cyc = cyc;
                end
            end else if (w_valid) begin
                chk("w_data", w_data, exp_q[0].d);
                chk("w_idx", {26'd0, w_idx}, {26'd0, exp_q[0].idx});
                chk("w_last", {31'd0, w_last}, {31'd0, exp_q[0].last});
                if (w_ready) begin
                    if (exp_q[0].last) last_hs_cyc = cyc;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- w_ready driver ----------------
    logic ready_rand = 1'b0;
    always @(posedge clk) begin
        #1;
        w_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_accept();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!blk_ready && n < 500);
        if (n >= 500) begin
            failures++;
            $display("FAIL accept_timeout blk_ready stuck low");
        end
    endtask

    task automatic send(input logic [511:0] d);
        blk_valid = 1'b1;
        blk_data  = d;
        wait_accept();
        @(posedge clk); #1;
        blk_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || w_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            failures++;
            $display("FAIL idle_timeout stream did not finish, queue=%0d", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    logic [511:0]     abc_blk, zero_blk, ones_blk;
    logic [64*32-1:0] ref_s;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        abc_blk  = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0]    = 32'h00000018;
        zero_blk = '0;
        ones_blk = '1;

        rst       = 1'b1;
        blk_valid = 1'b0;
        blk_data  = '0;
        w_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_w_valid", {31'd0, w_valid}, 32'd0);
        chk("rst_w_data", w_data, 32'd0);
        chk("rst_w_idx", {26'd0, w_idx}, 32'd0);
        chk("rst_w_last", {31'd0, w_last}, 32'd0);
        chk("rst_blk_ready", {31'd0, blk_ready}, 32'd1);

        // Pin the reference model with hand-computed values.
        ref_s = sched(abc_blk);
        chk("model_abc_w0", ref_s[0*32 +: 32], 32'h61626380);
        chk("model_abc_w15", ref_s[15*32 +: 32], 32'h00000018);
        chk("model_abc_w16", ref_s[16*32 +: 32], 32'h61626380);
        chk("model_abc_w17", ref_s[17*32 +: 32], 32'h000F0000);
        chk("model_abc_w18", ref_s[18*32 +: 32], 32'h7DA86405);
        ref_s = sched(ones_blk);
        chk("model_ones_w16", ref_s[16*32 +: 32], 32'h203FFFFC);
        ref_s = sched(zero_blk);
        chk("model_zero_w63", ref_s[63*32 +: 32], 32'h00000000);

        @(posedge clk); #1;

        // "abc" with w_ready high, then with random backpressure.
        send(abc_blk);
        wait_idle();
        ready_rand = 1'b1;
        send(abc_blk);
        wait_idle();

        // Zero and all-ones blocks, then random blocks, under backpressure.
        send(zero_blk);
        wait_idle();
        send(ones_blk);
        wait_idle();
        for (int k = 0; k < 4; k++) begin
            send(rand_blk());
            wait_idle();
        end

        // Back-to-back: blk_valid held high across two blocks.
        blk_valid = 1'b1;
        blk_data  = rand_blk();
        wait_accept();
        @(posedge clk); #1;
        blk_data = rand_blk();
        wait_accept();
        @(posedge clk); #1;
        blk_valid = 1'b0;
        chk("b2b_gap", acc_cyc, last_hs_cyc + 1);
        wait_idle();

        // Reset mid-stream at w_idx == 30.
        ready_rand = 1'b0;
        send(abc_blk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(w_valid && w_idx == 6'd29) && n < 200);
        if (n >= 200) begin
            failures++;
            $display("FAIL idx29_timeout w_idx=%0d", w_idx);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_w_idx", {26'd0, w_idx}, 32'd30);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_w_valid", {31'd0, w_valid}, 32'd0);
        chk("mid_rst_w_idx", {26'd0, w_idx}, 32'd0);
        chk("mid_rst_blk_ready", {31'd0, blk_ready}, 32'd1);
        @(posedge clk); #1;
        send(abc_blk);
        wait_idle();

        // blk_valid pulsed during RUN with other data must be ignored.
        ready_rand = 1'b1;
        send(abc_blk);
        repeat (5) begin
            @(posedge clk); #1;
        end
        blk_valid = 1'b1;
        blk_data  = rand_blk();
        repeat (3) begin
            @(posedge clk); #1;
        end
        blk_valid = 1'b0;
        wait_idle();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- Upstream neighbour of the sigma0/sigma1 word-expansion datapath.
- Accepts one padded 512-bit message block and holds a 16-word sliding window.
- Streams the round words W[0..NUM_ROUNDS-1] one per handshake to the compression core.
- W[0..15] come straight from the block; W[16..] are expanded on the fly, one new word per accepted output.

Parameters:
NUM_ROUNDS, 64, number of W words emitted per block; legal range 17..64; values below 64 are for reduced-round test only.

Ports:
clk  in  1  clock
rst  in  1  reset
blk_valid  in  1  upstream block available
blk_ready  out  1  block accepted when blk_valid && blk_ready
blk_data  in  512  padded block; word 0 in [511:480], word 15 in [31:0], each word big-endian
w_valid  out  1  w_data valid
w_ready  in  1  downstream accepts when w_valid && w_ready
w_data  out  32  current round word W[t]
w_idx  out  6  round index t
w_last  out  1  high while w_idx == NUM_ROUNDS-1 and w_valid

Behaviour:
- Reset: rst, synchronous, active-high; clock clk.
- Reset values: state=IDLE, window cleared to 0, w_valid=0, w_data=0, w_idx=0, w_last=0.
- blk_ready is combinational = (state==IDLE) && !rst.
- States:
  - IDLE: blk_ready=1, w_valid=0. On blk_valid && blk_ready, load win[0..15] = words 0..15 of blk_data and clear w_idx. Next cycle: RUN.
  - RUN: blk_ready=0, w_valid=1, w_data=win[0], w_idx=t.
    - On w_valid && w_ready: shift the window down (win[i] <= win[i+1]); win[15] <= new_w; t <= t+1.
    - If t == NUM_ROUNDS-1 at handshake: go to IDLE, w_valid drops next cycle.
- new_w = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], modulo 2^32, where:
  - sigma0(x) = rotr7 ^ rotr18 ^ shr3
  - sigma1(x) = rotr17 ^ rotr19 ^ shr10
- new_w is computed every RUN handshake, including t < 16, so the window always reflects W[t..t+15].
- Latency: block accepted at cycle N gives W[0] valid at cycle N+1.
  - With w_ready held high, W[t] appears at N+1+t; the last word appears at N+NUM_ROUNDS.
  - A new block can be accepted at N+NUM_ROUNDS+1 (one bubble between blocks).
- Backpressure: while w_valid && !w_ready, w_data, w_idx and w_last hold stable; the window does not shift.
- blk_valid is ignored outside IDLE; blk_data is sampled only on the accept edge.
- rst mid-stream: abandon the block and return to reset values next cycle. No partial words are emitted afterwards.
- Simultaneous rst and blk_valid: rst wins; the block is not accepted.
- w_idx wraps never: it is bounded by NUM_ROUNDS-1 and cleared on load.

Decomposition:
- Shared package sha256_pkg holds:
  - word_t (32-bit)
  - SHA256_BLOCK_W = 512
  - SHA256_WORDS = 16
  - SHA256_ROUNDS = 64
  - functions rotr, sigma0_small, sigma1_small (also used by the expansion and compression stages)
- Sub-module sha256_w_expand: combinational, inputs win[0], win[1], win[9], win[14], output new_w. It is separately unit-testable.

Test Plan:
- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> W[0]=0x61626380, W[15]=0x00000018, W[16]=0x61626380, W[17]=0x000F0000, W[18]=0x7DA86405; 64 words with w_last only at w_idx=63; blk_ready returns high the cycle after.
- Same block with w_ready toggled pseudo-randomly (about 50%) -> identical 64-word sequence matching the C/Python reference model; outputs stable during every stall cycle.
- All-zero block -> all 64 words = 0x00000000; all-ones block -> W[16] = sigma1(0xFFFFFFFF) + 0xFFFFFFFF + sigma0(0xFFFFFFFF) + 0xFFFFFFFF mod 2^32, checked against the model (exercises the carry wrap).
- Two blocks offered back-to-back with blk_valid held high -> second accepted exactly one cycle after the first block's w_last handshake; the second stream is correct and independent of the first.
- rst asserted at w_idx=30 -> next cycle w_valid=0, w_idx=0, blk_ready=1; a fresh "abc" block afterwards yields the correct W[0..63].
- blk_valid pulsed during RUN with different data -> ignored; the current stream is unaffected.
